// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the
// instruction hand-off to the decoder/core.
interface instr_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        branch_taken_i;
    logic [31:0] instr_o;
    logic [5:0]  instr_op_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_err_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i,
        output instr_valid_o,
        input  instr_ready_i,
        input  branch_taken_i,
        output instr_o,
        output instr_op_o,
        output pc_o,
        output pc_plus4_o,
        output fetch_err_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i,
        input  instr_valid_o,
        output instr_ready_i,
        output branch_taken_i,
        input  instr_o,
        input  instr_op_o,
        input  pc_o,
        input  pc_plus4_o,
        input  fetch_err_o
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: owns the PC, fetches one word per instruction over a
// req/ack handshake, holds it for the core and redirects on taken beq.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    instr_fetch_unit_if.master         bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_valid;
    logic             r_err;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_off;
    logic [31:0]      w_br_target;

    // beq target: word offset sign-extended and scaled, relative to pc+4
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_target = w_pc_plus4 + w_br_off;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                    r_cnt   <= '0;
                end
                S_REQ: begin
                    // ack beats a coincident timeout
                    if (bus.imem_ack_i) begin
                        r_instr <= bus.imem_rdata_i;
                        r_cnt   <= '0;
                        r_state <= S_VALID;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                    end else if (r_cnt == LAST_WAIT) begin
                        r_err <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_VALID: begin
                    if (bus.instr_ready_i) begin
                        r_pc    <= bus.branch_taken_i ? w_br_target : w_pc_plus4;
                        r_state <= S_REQ;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.imem_req_o    = r_req;
    assign bus.imem_addr_o   = r_pc;
    assign bus.instr_valid_o = r_valid;
    assign bus.instr_o       = r_instr;
    assign bus.instr_op_o    = r_instr[31:26];
    assign bus.pc_o          = r_pc;
    assign bus.pc_plus4_o    = w_pc_plus4;
    assign bus.fetch_err_o   = r_err;

    // Request and valid phases never overlap
    a_req_valid_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(r_req && r_valid));

    // Error pulse only ever follows a request cycle
    a_err_in_req: assert property (@(posedge clk_i) disable iff (!rst_i)
        r_err |-> r_req);

    generate
        if (RESET_PC[1:0] == 2'b00) begin : g_align_chk
            a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_i)
                r_pc[1:0] == 2'b00);
        end
    endgenerate

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (RESET_PC=0 and
// RESET_PC=0xFFFF_FFFC), hand-computed expectations per scenario task.
module tb_instr_fetch_unit;

    logic clk;
    logic rst_n;
    logic rst1_n;
    int   errors;
    int   checks;

    instr_fetch_unit_if if0();
    instr_fetch_unit_if if1();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (if0)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst1_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: return word for the pending request of instance 0
    task automatic present(input logic [31:0] word);
        if0.imem_ack_i   = 1'b1;
        if0.imem_rdata_i = word;
        tick();
        if0.imem_ack_i   = 1'b0;
        if0.imem_rdata_i = 32'd0;
    endtask

    // Stimulus only: retire the presented instruction of instance 0
    task automatic retire(input logic taken);
        if0.instr_ready_i  = 1'b1;
        if0.branch_taken_i = taken;
        tick();
        if0.instr_ready_i  = 1'b0;
        if0.branch_taken_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        tick();
        tick();
        checks++;
        if (if0.imem_req_o !== 1'b0 || if0.instr_valid_o !== 1'b0 || if0.fetch_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b valid=%b err=%b expected 0 0 0",
                     if0.imem_req_o, if0.instr_valid_o, if0.fetch_err_o);
        end
        checks++;
        if (if0.pc_o !== 32'h0 || if0.instr_o !== 32'h0 || if0.pc_plus4_o !== 32'h4) begin
            errors++;
            $display("FAIL reset_data: got pc=%h instr=%h pc4=%h expected 0 0 4",
                     if0.pc_o, if0.instr_o, if0.pc_plus4_o);
        end
        checks++;
        if (if1.pc_o !== 32'hFFFF_FFFC || if1.pc_plus4_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc1: got pc=%h pc4=%h expected fffffffc 0",
                     if1.pc_o, if1.pc_plus4_o);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (if0.imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release: got req=%b expected 0", if0.imem_req_o);
        end
        tick();
        checks++;
        if (if0.imem_req_o !== 1'b1 || if0.imem_addr_o !== 32'h0 || if0.instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h valid=%b expected 1 0 0",
                     if0.imem_req_o, if0.imem_addr_o, if0.instr_valid_o);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            present(32'h2009_0005);
            checks++;
            if (if0.instr_valid_o !== 1'b1 || if0.imem_req_o !== 1'b0 || if0.instr_o !== 32'h2009_0005) begin
                errors++;
                $display("FAIL seq_valid[%0d]: got valid=%b req=%b instr=%h expected 1 0 20090005",
                         k, if0.instr_valid_o, if0.imem_req_o, if0.instr_o);
            end
            checks++;
            if (if0.instr_op_o !== 6'h08) begin
                errors++;
                $display("FAIL seq_op[%0d]: got %h expected 08", k, if0.instr_op_o);
            end
            checks++;
            if (if0.pc_o !== 32'(4 * k) || if0.pc_plus4_o !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL seq_pc[%0d]: got pc=%h pc4=%h expected %h %h",
                         k, if0.pc_o, if0.pc_plus4_o, 32'(4 * k), 32'(4 * k + 4));
            end
            retire(1'b0);
            checks++;
            if (if0.imem_req_o !== 1'b1 || if0.instr_valid_o !== 1'b0 || if0.imem_addr_o !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL seq_next_req[%0d]: got req=%b valid=%b addr=%h expected 1 0 %h",
                         k, if0.imem_req_o, if0.instr_valid_o, if0.imem_addr_o, 32'(4 * k + 4));
            end
        end
    endtask

    task automatic test_hold();
        present(32'h2009_0005);
        // Ready low; ack/taken/rdata noise must all be ignored in VALID
        if0.imem_ack_i     = 1'b1;
        if0.imem_rdata_i   = 32'hDEAD_BEEF;
        if0.branch_taken_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if0.instr_valid_o !== 1'b1 || if0.imem_req_o !== 1'b0 ||
                if0.instr_o !== 32'h2009_0005 || if0.pc_o !== 32'hC) begin
                errors++;
                $display("FAIL hold[%0d]: got valid=%b req=%b instr=%h pc=%h expected 1 0 20090005 0000000c",
                         i, if0.instr_valid_o, if0.imem_req_o, if0.instr_o, if0.pc_o);
            end
        end
        if0.imem_ack_i     = 1'b0;
        if0.imem_rdata_i   = 32'd0;
        if0.branch_taken_i = 1'b0;
        retire(1'b0);
        checks++;
        if (if0.imem_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL hold_release: got addr=%h expected 00000010", if0.imem_addr_o);
        end
    endtask

    task automatic test_branch();
        // pc 0x10, offset +11 words -> 0x14 + 0x2C = 0x40
        present(32'h1000_000B);
        retire(1'b1);
        checks++;
        if (if0.imem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL branch_fwd: got addr=%h expected 00000040", if0.imem_addr_o);
        end
        present(32'h1000_FFFC);
        checks++;
        if (if0.instr_op_o !== 6'h04 || if0.pc_o !== 32'h40) begin
            errors++;
            $display("FAIL branch_op: got op=%h pc=%h expected 04 00000040", if0.instr_op_o, if0.pc_o);
        end
        retire(1'b1);
        checks++;
        if (if0.imem_addr_o !== 32'h34 || if0.imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL branch_back_taken: got addr=%h req=%b expected 00000034 1",
                     if0.imem_addr_o, if0.imem_req_o);
        end
        // 0x34 + 4 + 2 words -> 0x40
        present(32'h1000_0002);
        retire(1'b1);
        checks++;
        if (if0.imem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL branch_return: got addr=%h expected 00000040", if0.imem_addr_o);
        end
        present(32'h1000_FFFC);
        retire(1'b0);
        checks++;
        if (if0.imem_addr_o !== 32'h44) begin
            errors++;
            $display("FAIL branch_not_taken: got addr=%h expected 00000044", if0.imem_addr_o);
        end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (if0.fetch_err_o !== 1'b0 || if0.imem_req_o !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: got err=%b req=%b expected 0 1",
                         i, if0.fetch_err_o, if0.imem_req_o);
            end
        end
        tick();
        checks++;
        if (if0.fetch_err_o !== 1'b1 || if0.imem_req_o !== 1'b1 || if0.imem_addr_o !== 32'h44) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b req=%b addr=%h expected 1 1 00000044",
                     if0.fetch_err_o, if0.imem_req_o, if0.imem_addr_o);
        end
        tick();
        checks++;
        if (if0.fetch_err_o !== 1'b0 || if0.imem_req_o !== 1'b1 || if0.imem_addr_o !== 32'h44) begin
            errors++;
            $display("FAIL timeout_single: got err=%b req=%b addr=%h expected 0 1 00000044",
                     if0.fetch_err_o, if0.imem_req_o, if0.imem_addr_o);
        end
        tick();
        present(32'h2009_0005);
        checks++;
        if (if0.instr_valid_o !== 1'b1 || if0.fetch_err_o !== 1'b0 || if0.pc_o !== 32'h44) begin
            errors++;
            $display("FAIL retry_ack: got valid=%b err=%b pc=%h expected 1 0 00000044",
                     if0.instr_valid_o, if0.fetch_err_o, if0.pc_o);
        end
        retire(1'b0);
        checks++;
        if (if0.imem_addr_o !== 32'h48) begin
            errors++;
            $display("FAIL retry_next: got addr=%h expected 00000048", if0.imem_addr_o);
        end
    endtask

    task automatic test_wrap();
        rst1_n = 1'b1;
        tick();
        checks++;
        if (if1.imem_req_o !== 1'b1 || if1.imem_addr_o !== 32'hFFFF_FFFC || if1.pc_plus4_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req: got req=%b addr=%h pc4=%h expected 1 fffffffc 0",
                     if1.imem_req_o, if1.imem_addr_o, if1.pc_plus4_o);
        end
        if1.imem_ack_i   = 1'b1;
        if1.imem_rdata_i = 32'h1000_FFFC;
        tick();
        if1.imem_ack_i    = 1'b0;
        if1.instr_ready_i = 1'b1;
        tick();
        if1.instr_ready_i = 1'b0;
        checks++;
        if (if1.pc_o !== 32'h0 || if1.imem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc: got pc=%h req=%b expected 0 1", if1.pc_o, if1.imem_req_o);
        end
        // Ack lands on the edge that would otherwise time out
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (if1.fetch_err_o !== 1'b0 || if1.instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL coinc_pre: got err=%b valid=%b expected 0 0", if1.fetch_err_o, if1.instr_valid_o);
        end
        if1.imem_ack_i   = 1'b1;
        if1.imem_rdata_i = 32'h2009_0005;
        tick();
        if1.imem_ack_i   = 1'b0;
        checks++;
        if (if1.fetch_err_o !== 1'b0 || if1.instr_valid_o !== 1'b1 || if1.instr_o !== 32'h2009_0005) begin
            errors++;
            $display("FAIL coinc_ack_wins: got err=%b valid=%b instr=%h expected 0 1 20090005",
                     if1.fetch_err_o, if1.instr_valid_o, if1.instr_o);
        end
        tick();
        checks++;
        if (if1.fetch_err_o !== 1'b0) begin
            errors++;
            $display("FAIL coinc_no_late_err: got err=%b expected 0", if1.fetch_err_o);
        end
    endtask

    task automatic test_reset_mid();
        present(32'h2009_0005);
        #3;
        rst_n = 1'b0;
        if0.imem_ack_i   = 1'b1;
        if0.imem_rdata_i = 32'hCAFE_F00D;
        #1;
        checks++;
        if (if0.instr_valid_o !== 1'b0 || if0.imem_req_o !== 1'b0 || if0.pc_o !== 32'h0 ||
            if0.instr_o !== 32'h0 || if0.instr_op_o !== 6'h0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b req=%b pc=%h instr=%h op=%h expected 0 0 0 0 0",
                     if0.instr_valid_o, if0.imem_req_o, if0.pc_o, if0.instr_o, if0.instr_op_o);
        end
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (if0.imem_req_o !== 1'b1 || if0.instr_valid_o !== 1'b0 || if0.imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_req: got req=%b valid=%b addr=%h expected 1 0 0",
                     if0.imem_req_o, if0.instr_valid_o, if0.imem_addr_o);
        end
        tick();
        if0.imem_ack_i = 1'b0;
        checks++;
        if (if0.instr_valid_o !== 1'b1 || if0.instr_o !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL post_reset_fetch: got valid=%b instr=%h expected 1 cafef00d",
                     if0.instr_valid_o, if0.instr_o);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        if0.imem_ack_i = 1'b0; if0.imem_rdata_i = 32'd0;
        if0.instr_ready_i = 1'b0; if0.branch_taken_i = 1'b0;
        if1.imem_ack_i = 1'b0; if1.imem_rdata_i = 32'd0;
        if1.instr_ready_i = 1'b0; if1.branch_taken_i = 1'b0;

        test_reset();
        test_sequential();
        test_hold();
        test_branch();
        test_timeout();
        test_wrap();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
